// File: rtl/decode_stage_if.sv
// ID/EX pipeline bundle between the decode stage (master) and execute (slave).
// The execute side returns ex_ready to accept the registered contents.
interface decode_stage_if;
    logic        ex_ready;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_dst_reg;
    logic [3:0]  id_src_reg1;
    logic [3:0]  id_src_reg2;
    logic [15:0] id_op1;
    logic [15:0] id_op2;
    logic [15:0] id_imm;
    logic [2:0]  id_cond;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_halt;

    modport master (
        input  ex_ready,
        output id_valid, id_opcode, id_dst_reg, id_src_reg1, id_src_reg2,
               id_op1, id_op2, id_imm, id_cond,
               id_reg_write, id_mem_read, id_mem_write, id_halt
    );

    modport slave (
        output ex_ready,
        input  id_valid, id_opcode, id_dst_reg, id_src_reg1, id_src_reg2,
               id_op1, id_op2, id_imm, id_cond,
               id_reg_write, id_mem_read, id_mem_write, id_halt
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage of the 16-bit core: field decode, write-back bypass, load-use
// interlock, ID/EX pipeline register and the RUN/HALTED issue state machine.
module decode_stage (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [15:0]           if_instr,
    input  logic [15:0]           if_pc_plus2,
    input  logic                  flush,
    input  logic                  wb_write,
    input  logic [3:0]            wb_dst_reg,
    input  logic [15:0]           wb_data,
    output logic [3:0]            rf_src_reg1,
    output logic [3:0]            rf_src_reg2,
    input  logic [15:0]           rf_src_data1,
    input  logic [15:0]           rf_src_data2,
    output logic                  stall_if,
    decode_stage_if.master        id_ex
);

    typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} halt_state_t;

    halt_state_t state_r, state_next_s;

    logic [3:0]  opcode_s, dst_s, src1_s, src2_s;
    logic [15:0] imm_s, op1_s, op2_s;
    logic [2:0]  cond_s;
    logic        reg_write_s, mem_read_s, mem_write_s, halt_s, use_pc_s;
    logic        hazard_s, load_s, bubble_s, stall_s;

    logic        valid_r, reg_write_r, mem_read_r, mem_write_r, halt_r;
    logic [3:0]  opcode_r, dst_r, src1_r, src2_r;
    logic [15:0] op1_r, op2_r, imm_r;
    logic [2:0]  cond_r;

    // Field decode; unused source fields stay at R0 so they can never hazard
    always_comb begin
        opcode_s    = if_instr[15:12];
        dst_s       = 4'd0;
        src1_s      = 4'd0;
        src2_s      = 4'd0;
        imm_s       = 16'h0000;
        cond_s      = 3'd0;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        halt_s      = 1'b0;
        use_pc_s    = 1'b0;
        case (opcode_s)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dst_s       = if_instr[11:8];
                src1_s      = if_instr[7:4];
                src2_s      = if_instr[3:0];
                reg_write_s = 1'b1;
            end
            4'h8: begin
                dst_s       = if_instr[11:8];
                src1_s      = if_instr[7:4];
                imm_s       = {{11{if_instr[3]}}, if_instr[3:0], 1'b0};
                mem_read_s  = 1'b1;
                reg_write_s = 1'b1;
            end
            4'h9: begin
                src1_s      = if_instr[7:4];
                src2_s      = if_instr[11:8];
                imm_s       = {{11{if_instr[3]}}, if_instr[3:0], 1'b0};
                mem_write_s = 1'b1;
            end
            4'hA, 4'hB: begin
                dst_s       = if_instr[11:8];
                src1_s      = if_instr[11:8];
                imm_s       = {8'h00, if_instr[7:0]};
                reg_write_s = 1'b1;
            end
            4'hC: begin
                cond_s      = if_instr[11:9];
                imm_s       = {{6{if_instr[8]}}, if_instr[8:0], 1'b0};
            end
            4'hD: begin
                cond_s      = if_instr[11:9];
                src1_s      = if_instr[7:4];
            end
            4'hE: begin
                dst_s       = if_instr[11:8];
                use_pc_s    = 1'b1;
                reg_write_s = 1'b1;
            end
            4'hF: begin
                halt_s      = 1'b1;
            end
            default: begin
                halt_s      = 1'b0;
            end
        endcase
    end

    // Operand select with write-back bypass; R0 writes are never forwarded
    always_comb begin
        op1_s = rf_src_data1;
        op2_s = rf_src_data2;
        if (use_pc_s) begin
            op1_s = if_pc_plus2;
        end else if (wb_write && (wb_dst_reg != 4'd0) && (wb_dst_reg == src1_s)) begin
            op1_s = wb_data;
        end else begin
            op1_s = rf_src_data1;
        end
        if (wb_write && (wb_dst_reg != 4'd0) && (wb_dst_reg == src2_s)) begin
            op2_s = wb_data;
        end else begin
            op2_s = rf_src_data2;
        end
    end

    assign hazard_s = if_valid && valid_r && mem_read_r && (dst_r != 4'd0) &&
                      ((dst_r == src1_s) || (dst_r == src2_s));

    // Slot priority: flush, halted, back-pressure, interlock, then accept
    always_comb begin
        stall_s      = 1'b0;
        load_s       = 1'b0;
        bubble_s     = 1'b0;
        state_next_s = state_r;
        if (!rst) begin
            stall_s = 1'b0;
        end else if (flush && (state_r == RUN)) begin
            bubble_s = 1'b1;
        end else if (state_r == HALTED) begin
            stall_s  = 1'b1;
            bubble_s = id_ex.ex_ready;
        end else if (!id_ex.ex_ready) begin
            stall_s = 1'b1;
        end else if (hazard_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else if (!if_valid) begin
            bubble_s = 1'b1;
        end else begin
            load_s = 1'b1;
            if (halt_s) begin
                state_next_s = HALTED;
            end else begin
                state_next_s = state_r;
            end
        end
    end

    // Halt state register; only reset leaves HALTED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // ID/EX pipeline register; bubbles clear every field
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble_s) begin
            valid_r     <= 1'b0;
            opcode_r    <= 4'd0;
            dst_r       <= 4'd0;
            src1_r      <= 4'd0;
            src2_r      <= 4'd0;
            op1_r       <= 16'h0000;
            op2_r       <= 16'h0000;
            imm_r       <= 16'h0000;
            cond_r      <= 3'd0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            halt_r      <= 1'b0;
        end else if (load_s) begin
            valid_r     <= 1'b1;
            opcode_r    <= opcode_s;
            dst_r       <= dst_s;
            src1_r      <= src1_s;
            src2_r      <= src2_s;
            op1_r       <= op1_s;
            op2_r       <= op2_s;
            imm_r       <= imm_s;
            cond_r      <= cond_s;
            reg_write_r <= reg_write_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            halt_r      <= halt_s;
        end
    end

    assign rf_src_reg1        = src1_s;
    assign rf_src_reg2        = src2_s;
    assign stall_if           = stall_s;
    assign id_ex.id_valid     = valid_r;
    assign id_ex.id_opcode    = opcode_r;
    assign id_ex.id_dst_reg   = dst_r;
    assign id_ex.id_src_reg1  = src1_r;
    assign id_ex.id_src_reg2  = src2_r;
    assign id_ex.id_op1       = op1_r;
    assign id_ex.id_op2       = op2_r;
    assign id_ex.id_imm       = imm_r;
    assign id_ex.id_cond      = cond_r;
    assign id_ex.id_reg_write = reg_write_r;
    assign id_ex.id_mem_read  = mem_read_r;
    assign id_ex.id_mem_write = mem_write_r;
    assign id_ex.id_halt      = halt_r;

endmodule
